// File: rtl/divider_64b_reg_if.sv
// Start/valid bundle between the arithmetic controller and divider_64b_reg.
// Operand and result widths follow WIDTH.
interface divider_64b_reg_if #(
    parameter int WIDTH = 64
);
    logic             iStart;
    logic             iSigned;
    logic [WIDTH-1:0] iDividend;
    logic [WIDTH-1:0] iDivisor;
    logic             oBusy;
    logic             oValid;
    logic [WIDTH-1:0] oQuotient;
    logic [WIDTH-1:0] oRemainder;
    logic             oDivZero;

    modport master (
        output iStart, iSigned, iDividend, iDivisor,
        input  oBusy, oValid, oQuotient, oRemainder, oDivZero
    );

    modport slave (
        input  iStart, iSigned, iDividend, iDivisor,
        output oBusy, oValid, oQuotient, oRemainder, oDivZero
    );
endinterface

// File: rtl/divider_64b_reg.sv
// Iterative restoring divider, one quotient bit per enabled cycle.
// Define DIVIDER_64B_REG_SIGNED_EN to honour iSigned (adds the FIX state).
module divider_64b_reg #(
    parameter int WIDTH = 64
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iEn,
    input  logic iClr,
    divider_64b_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
`ifdef DIVIDER_64B_REG_SIGNED_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_o_q, quo_o_d;
    logic [WIDTH-1:0] rem_o_q, rem_o_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
`ifdef DIVIDER_64B_REG_SIGNED_EN
    logic             sgn_q, sgn_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             sd, ss;
`else
    logic             unused_signed;
    assign unused_signed = bus.iSigned;
`endif

    // acc holds the unconsumed dividend bits and collects quotient bits in their place
    assign rem_sh = {rem_q, acc_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_o_d = quo_o_q;
        rem_o_d = rem_o_q;
        dz_d    = dz_q;
`ifdef DIVIDER_64B_REG_SIGNED_EN
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        sd      = bus.iSigned & bus.iDividend[WIDTH-1];
        ss      = bus.iSigned & bus.iDivisor[WIDTH-1];
`endif
        if (iClr) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            dvs_d   = '0;
            rem_d   = '0;
            quo_o_d = '0;
            rem_o_d = '0;
            dz_d    = 1'b0;
`ifdef DIVIDER_64B_REG_SIGNED_EN
            sgn_d   = 1'b0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
`endif
        end else if (iEn) begin
            unique case (1'b1)
                (state_q == IDLE),
                (state_q == DONE): begin
                    if (bus.iStart) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        rem_d   = '0;
`ifdef DIVIDER_64B_REG_SIGNED_EN
                        acc_d   = sd ? -bus.iDividend : bus.iDividend;
                        dvs_d   = ss ? -bus.iDivisor : bus.iDivisor;
                        sgn_d   = bus.iSigned;
                        negq_d  = sd ^ ss;
                        negr_d  = sd;
`else
                        acc_d   = bus.iDividend;
                        dvs_d   = bus.iDivisor;
`endif
                    end
                end
                (state_q == BUSY): begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = {acc_q[WIDTH-2:0], ge};
                    rem_d = ge ? rem_sh[WIDTH-1:0] - dvs_q
                               : rem_sh[WIDTH-1:0];
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        quo_o_d = {acc_q[WIDTH-2:0], ge};
                        rem_o_d = rem_d;
                        dz_d    = (dvs_q == '0);
`ifdef DIVIDER_64B_REG_SIGNED_EN
                        state_d = sgn_q ? FIX : DONE;
`else
                        state_d = DONE;
`endif
                    end
                end
`ifdef DIVIDER_64B_REG_SIGNED_EN
                // divide-by-zero keeps the all-ones quotient; remainder sign restores the dividend
                (state_q == FIX): begin
                    if (negq_q && !dz_q) quo_o_d = -quo_o_q;
                    if (negr_q)          rem_o_d = -rem_o_q;
                    state_d = DONE;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_o_q <= '0;
            rem_o_q <= '0;
            dz_q    <= 1'b0;
`ifdef DIVIDER_64B_REG_SIGNED_EN
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_o_q <= quo_o_d;
            rem_o_q <= rem_o_d;
            dz_q    <= dz_d;
`ifdef DIVIDER_64B_REG_SIGNED_EN
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

`ifdef DIVIDER_64B_REG_SIGNED_EN
    assign bus.oBusy = (state_q == BUSY) || (state_q == FIX);
`else
    assign bus.oBusy = (state_q == BUSY);
`endif
    assign bus.oValid     = (state_q == DONE);
    assign bus.oQuotient  = quo_o_q;
    assign bus.oRemainder = rem_o_q;
    assign bus.oDivZero   = dz_q;
endmodule
